// File: rtl/rls_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rls_pkg : shared state encoding and fixed-point helpers for the RLS path  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package rls_pkg;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  // Widest element the shift/saturate helper supports.
  localparam int c_maxw = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Returns {overflow, value}; value is valid in its low `width` bits.
  function automatic logic [c_maxw:0] fx_shift_sat(
    input logic signed [2*c_maxw-1:0] p,
    input int                         width,
    input int                         frac,
    input logic                       sat
  );
    logic signed [2*c_maxw-1:0] q;
    logic signed [2*c_maxw-1:0] hi;
    logic signed [2*c_maxw-1:0] lo;
    logic                       o;
    q  = p >>> frac;
    hi = (128'sd1 <<< (width - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (width - 1));
    o  = 1'b0;
    if (sat && (q > hi)) begin
      q = hi;
      o = 1'b1;
    end else if (sat && (q < lo)) begin
      q = lo;
      o = 1'b1;
    end
    return {o, q[c_maxw-1:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fx_mult_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fx_mult_lane : combinational signed multiply, >>> FRAC, optional clamp    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fx_mult_lane
  import rls_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int SATURATE = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p,
  output logic             ovf
);

  logic signed [2*WIDTH-1:0]  w_prod;
  logic signed [2*c_maxw-1:0] w_prod_ext;
  logic        [c_maxw:0]     w_res;

  assign w_prod     = (2*WIDTH)'($signed(a)) * (2*WIDTH)'($signed(b));
  assign w_prod_ext = (2*c_maxw)'(w_prod);
  assign w_res      = fx_shift_sat(w_prod_ext, WIDTH, FRAC, SATURATE != 0);
  assign p          = w_res[WIDTH-1:0];
  assign ovf        = w_res[c_maxw];

  if (WIDTH < c_maxw) begin : g_unused
    logic w_unused;
    assign w_unused = ^w_res[c_maxw-1:WIDTH];
  end

endmodule
`default_nettype wire

// File: rtl/scalar_vec_mult_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scalar_vec_mult_seq : scalar x vector multiplier, LANES products per beat |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module scalar_vec_mult_seq
  import rls_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE_B   = 16,
  parameter int LANES    = 4,
  parameter int FRAC     = 16,
  parameter int SATURATE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH*SIZE_B-1:0]   b,
  output logic                      busy,
  output logic                      done,
  output logic                      ovf,
  output logic [WIDTH*SIZE_B-1:0]   y
);

  localparam int c_nb = (SIZE_B + LANES - 1) / LANES;
  localparam int c_cw = (clog2(c_nb) < 1) ? 1 : clog2(c_nb);
  localparam logic [c_cw-1:0] c_last = c_cw'(c_nb - 1);

  logic [1:0]                    r_state;
  logic [1:0]                    w_state_nxt;
  logic [c_cw-1:0]               r_cnt;
  logic [WIDTH-1:0]              r_a;
  logic [WIDTH*SIZE_B-1:0]       r_b;
  logic [WIDTH*SIZE_B-1:0]       r_buf;
  logic [WIDTH*SIZE_B-1:0]       r_y;
  logic                          r_sovf;
  logic                          r_done;
  logic                          r_ovf;
  logic                          w_accept;
  logic                          w_last;
  int                            w_base;
  logic [LANES-1:0][WIDTH-1:0]   w_lane_b;
  logic [LANES-1:0][WIDTH-1:0]   w_lane_p;
  logic [LANES-1:0]              w_lane_v;
  logic [LANES-1:0]              w_lane_ovf;

  assign w_accept = start && (r_state != c_st_run);
  assign w_last   = (r_cnt == c_last);
  assign w_base   = int'(r_cnt) * LANES;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (start) w_state_nxt = c_st_run;
      c_st_run:  if (w_last) w_state_nxt = c_st_done;
      c_st_done: w_state_nxt = start ? c_st_run : c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    busy = (r_state == c_st_run);
    done = r_done;
    ovf  = r_ovf;
    y    = r_y;
  end

  // Lanes past the end of the vector on the final beat stay invalid.
  always_comb begin
    w_lane_b = '0;
    w_lane_v = '0;
    for (int l = 0; l < LANES; l++) begin
      if (w_base + l < SIZE_B) begin
        w_lane_v[l] = 1'b1;
        w_lane_b[l] = r_b[(w_base + l)*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fx_mult_lane #(
      .WIDTH    (WIDTH),
      .FRAC     (FRAC),
      .SATURATE (SATURATE)
    ) u_lane (
      .a   (r_a),
      .b   (w_lane_b[g]),
      .p   (w_lane_p[g]),
      .ovf (w_lane_ovf[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_buf  <= '0;
      r_y    <= '0;
      r_sovf <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == c_st_done) begin
        r_y    <= r_buf;
        r_ovf  <= r_sovf;
        r_done <= 1'b1;
      end
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_cnt  <= '0;
        r_sovf <= 1'b0;
      end else if (r_state == c_st_run) begin
        for (int l = 0; l < LANES; l++) begin
          if (w_lane_v[l]) r_buf[(w_base + l)*WIDTH +: WIDTH] <= w_lane_p[l];
        end
        r_sovf <= r_sovf | (|(w_lane_ovf & w_lane_v));
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scalar_vec_mult_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_scalar_vec_mult_seq : directed + random checks on two configurations   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_scalar_vec_mult_seq;

  localparam int NB_A = 4;  // SIZE_B=16, LANES=4
  localparam int NB_B = 3;  // SIZE_B=10, LANES=4

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_a = 1'b0, start_b = 1'b0;
  logic [31:0]  a_a = '0, a_b = '0;
  logic [511:0] b_a = '0;
  logic [319:0] b_b = '0;
  logic         busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [511:0] y_a;
  logic [319:0] y_b;
  int           n_tests = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  scalar_vec_mult_seq #(
    .WIDTH(32), .SIZE_B(16), .LANES(4), .FRAC(16), .SATURATE(1)
  ) u_a (
    .clk(clk), .reset(reset), .start(start_a), .a(a_a), .b(b_a),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .y(y_a)
  );

  scalar_vec_mult_seq #(
    .WIDTH(32), .SIZE_B(10), .LANES(4), .FRAC(16), .SATURATE(0)
  ) u_b (
    .clk(clk), .reset(reset), .start(start_b), .a(a_b), .b(b_b),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .y(y_b)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_elem();
    logic [31:0] e;
    e = $urandom;
    if ($urandom_range(1, 0) == 0) e = {{12{e[19]}}, e[19:0]};
    return e;
  endfunction

  function automatic logic [511:0] rand_vec();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = rand_elem();
    return v;
  endfunction

  // Reference: each element is floor(a*b / 2^16), clamped to int32 when saturating.
  function automatic void model(input int sel, input logic [31:0] av, input logic [511:0] bv,
                                output logic [511:0] ey, output logic eo);
    int     n;
    longint p, q;
    n  = (sel != 0) ? 10 : 16;
    ey = '0;
    eo = 1'b0;
    for (int i = 0; i < n; i++) begin
      p = longint'($signed(av)) * longint'($signed(bv[32*i +: 32]));
      q = p >>> 16;
      if (sel == 0 && q > 64'sd2147483647) begin
        ey[32*i +: 32] = 32'h7FFF_FFFF;
        eo = 1'b1;
      end else if (sel == 0 && q < -64'sd2147483648) begin
        ey[32*i +: 32] = 32'h8000_0000;
        eo = 1'b1;
      end else begin
        ey[32*i +: 32] = q[31:0];
      end
    end
  endfunction

  task automatic drive(input int sel, input logic st, input logic [31:0] av, input logic [511:0] bv);
    if (sel != 0) begin
      start_b = st; a_b = av; b_b = bv[319:0];
    end else begin
      start_a = st; a_a = av; b_a = bv;
    end
  endtask

  // One operation: latency, busy length, result, ovf, single-cycle done.
  // poke>0 pulses start while busy to confirm it is ignored.
  task automatic op(input int sel, input logic [31:0] av, input logic [511:0] bv,
                    input logic [511:0] ey, input logic eo, input int poke, input string tag);
    int nb, busy_cnt, done_at;
    nb = (sel != 0) ? NB_B : NB_A;
    @(negedge clk);
    drive(sel, 1'b1, av, bv);
    @(posedge clk); #1;
    drive(sel, 1'b0, rand_elem(), rand_vec());
    busy_cnt = ((sel != 0) ? busy_b : busy_a) ? 1 : 0;
    done_at  = 0;
    for (int k = 1; k <= nb + 3 && done_at == 0; k++) begin
      @(posedge clk); #1;
      drive(sel, (k == poke), rand_elem(), rand_vec());
      if ((sel != 0) ? busy_b : busy_a) busy_cnt++;
      if ((sel != 0) ? done_b : done_a) done_at = k;
    end
    chk({tag, "_latency"}, 512'(done_at), 512'(nb + 1));
    chk({tag, "_busy_cycles"}, 512'(busy_cnt), 512'(nb));
    chk({tag, "_y"}, (sel != 0) ? {192'b0, y_b} : y_a, ey);
    chk({tag, "_ovf"}, 512'((sel != 0) ? ovf_b : ovf_a), 512'(eo));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 512'((sel != 0) ? done_b : done_a), 512'(0));
  endtask

  initial begin
    logic [511:0] bv, ey;
    logic [31:0]  av;
    logic         eo, seen;
    logic [31:0]  bb_a[4];
    logic [511:0] bb_b[4];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 512'(busy_a), 512'(0));
    chk("rst_done", 512'(done_a), 512'(0));
    chk("rst_ovf", 512'(ovf_a), 512'(0));
    chk("rst_y", y_a, '0);
    chk("rst_y_b", {192'b0, y_b}, '0);
    @(negedge clk);
    reset = 1'b1;

    // Basic scale: 2.0 * i
    for (int i = 0; i < 16; i++) begin
      bv[32*i +: 32] = 32'(i) << 16;
      ey[32*i +: 32] = 32'(2 * i) << 16;
    end
    op(0, 32'h0002_0000, bv, ey, 1'b0, 0, "basic");

    // -1.0 * 3.0
    for (int i = 0; i < 16; i++) begin
      bv[32*i +: 32] = 32'h0003_0000;
      ey[32*i +: 32] = 32'hFFFD_0000;
    end
    op(0, 32'hFFFF_0000, bv, ey, 1'b0, 0, "neg");

    // 0.5 * -2^-16 truncates toward -inf
    for (int i = 0; i < 16; i++) begin
      bv[32*i +: 32] = 32'hFFFF_FFFF;
      ey[32*i +: 32] = 32'hFFFF_FFFF;
    end
    op(0, 32'h0000_8000, bv, ey, 1'b0, 0, "half");

    // Reset in the middle of an operation
    @(negedge clk);
    drive(0, 1'b1, 32'h0001_0000, rand_vec());
    @(posedge clk); #1;
    drive(0, 1'b0, rand_elem(), rand_vec());
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_busy", 512'(busy_a), 512'(0));
    chk("midrst_done", 512'(done_a), 512'(0));
    chk("midrst_ovf", 512'(ovf_a), 512'(0));
    chk("midrst_y", y_a, '0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done_a) seen = 1'b1;
    end
    chk("midrst_no_done", 512'(seen), 512'(0));
    av = rand_elem(); bv = rand_vec();
    model(0, av, bv, ey, eo);
    op(0, av, bv, ey, eo, 0, "after_rst");

    // Saturation, clamp and wrap variants
    bv = '0;
    bv[32*3 +: 32] = 32'h0002_0000;
    ey = '0;
    ey[32*3 +: 32] = 32'h7FFF_FFFF;
    op(0, 32'h7FFF_0000, bv, ey, 1'b1, 0, "sat_clamp");
    ey[32*3 +: 32] = 32'hFFFE_0000;
    op(1, 32'h7FFF_0000, bv, ey, 1'b0, 0, "sat_wrap");

    // Partial final beat (10 elements, 3 beats)
    av = rand_elem(); bv = rand_vec();
    model(1, av, bv, ey, eo);
    op(1, av, bv, ey, eo, 0, "partial");

    // start pulsed while busy is ignored
    av = rand_elem(); bv = rand_vec();
    model(0, av, bv, ey, eo);
    op(0, av, bv, ey, eo, 1, "poke");

    // start held high: back-to-back results every NB+1 cycles
    for (int j = 0; j < 4; j++) begin
      bb_a[j] = rand_elem();
      bb_b[j] = rand_vec();
    end
    @(negedge clk);
    drive(0, 1'b1, bb_a[0], bb_b[0]);
    @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      #1;
      drive(0, 1'b1, rand_elem(), rand_vec());
      repeat (NB_A) @(posedge clk);
      @(negedge clk);
      drive(0, (j < 2), bb_a[j+1], bb_b[j+1]);
      @(posedge clk); #1;
      model(0, bb_a[j], bb_b[j], ey, eo);
      chk($sformatf("b2b%0d_done", j), 512'(done_a), 512'(1));
      chk($sformatf("b2b%0d_y", j), y_a, ey);
    end
    @(posedge clk); #1;
    chk("b2b_end_done", 512'(done_a), 512'(0));

    // Random operations on both configurations
    for (int r = 0; r < 8; r++) begin
      av = rand_elem(); bv = rand_vec();
      model(r % 2, av, bv, ey, eo);
      op(r % 2, av, bv, ey, eo, 0, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scalar_vec_mult_seq.md
Name: scalar_vec_mult_seq

Overview:
- Parametrised, time-multiplexed scalar-by-vector multiplier for the RLS datapath (gain update and P-matrix row scaling).
- Multiplies one signed fixed-point scalar by a SIZE_B-element vector using LANES multipliers per cycle.
- Adds a start/done handshake, operand capture, fixed-point rescaling, optional saturation with an overflow flag, and any SIZE_B/LANES ratio (partial final beat).
- Output vector updates atomically once per operation.

Parameters:
- WIDTH, 32: element and scalar width, signed two's complement.
- SIZE_B, 16: vector length in elements, ≥1.
- LANES, 4: parallel multipliers, 1..SIZE_B.
- FRAC, 16: fractional bits; product is arithmetically shifted right by FRAC. Range 0..WIDTH-1.
- SATURATE, 1: 1 = clamp to signed WIDTH range; 0 = wrap (keep low WIDTH bits).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  scalar operand, captured on the accepted start.
- b  in  WIDTH*SIZE_B  vector operand, element i at [WIDTH*i +: WIDTH], captured on the accepted start.
- busy  out  1  high while an operation is in progress (state RUN).
- done  out  1  one-cycle pulse when y holds a new result.
- ovf  out  1  valid with done; high if any element saturated in that operation. Always 0 when SATURATE=0.
- y  out  WIDTH*SIZE_B  result vector, same packing as b. Holds until the next done.

Behaviour:
- Constants:
  - NB = ceil(SIZE_B/LANES) beats.
  - Beat counter width = clog2(NB), minimum 1.
- Reset, asynchronous while reset=0:
  - state=IDLE.
  - busy=0, done=0, ovf=0, y=0.
  - Beat counter=0, captured operands=0, working buffer=0, sticky overflow=0.
  - Reset asserted mid-operation aborts it; no done is produced.
- States:
  - IDLE: busy=0. If start=1 at an edge: capture a and b, clear the beat counter and sticky overflow, go to RUN.
  - RUN: busy=1. Each edge computes beat k = element indices k*LANES .. k*LANES+LANES-1.
    - Lanes with index ≥ SIZE_B are ignored; no write occurs.
    - Results are written to the working buffer and the beat counter increments.
    - On the edge processing beat NB-1, go to DONE.
  - DONE: busy=0.
    - At the next edge: y<=working buffer (including the final beat), ovf<=sticky overflow, done<=1 for exactly one cycle.
    - If start=1 at that same edge: capture new operands and go to RUN. Back-to-back throughput is NB+1 cycles per vector.
    - Otherwise go to IDLE.
- Latency: start accepted at edge E0 → done high in the cycle after edge E(NB+1). Example: SIZE_B=16, LANES=4 gives done after the 5th edge following acceptance.
- start while busy=1 is ignored. It is not queued and does not disturb captured operands.
- Operand inputs may change freely after acceptance.
- Arithmetic per lane:
  - p = signed(a) * signed(b_i), full 2*WIDTH bits.
  - q = p >>> FRAC, arithmetic (truncation toward −∞).
  - SATURATE=1: if q > 2^(WIDTH-1)-1 → max; if q < −2^(WIDTH-1) → min; set sticky overflow. Else low WIDTH bits of q.
  - SATURATE=0: low WIDTH bits of q, no flag.
- y never shows a partially updated vector.

Decomposition:
- Shared package rls_pkg holds:
  - State encoding (IDLE/RUN/DONE).
  - A clog2 constant function.
  - A helper function for fixed-point shift-and-saturate.
- One sub-module, fx_mult_lane: a purely combinational single signed multiply + shift + saturate with an overflow bit, instantiated LANES times via generate.
- The top holds the FSM, beat counter, lane-select muxing, working buffer and output register.

Test Plan:
- Basic scale (WIDTH=32, FRAC=16, SIZE_B=16, LANES=4): a=0x00020000, b_i=i<<16 → y_i=(2i)<<16, ovf=0. done pulses once, exactly 5 edges after start; busy high for 4 cycles.
- Negative/rounding: a=0xFFFF0000 (−1.0), b_i=0x00030000 → y_i=0xFFFD0000. Also a=0x00008000 (0.5), b_i=0xFFFFFFFF → y_i=0xFFFFFFFF (truncation toward −∞).
- Saturation: a=0x7FFF0000, b_3=0x00020000, other elements 0 → y_3=0x7FFFFFFF, others 0, ovf=1. Same stimulus with SATURATE=0 → y_3=0xFFFE0000, ovf=0.
- Partial beat: SIZE_B=10, LANES=4 → NB=3, done 4 edges after start. All 10 elements correct; no spurious writes.
- Handshake: start held high continuously → done every NB+1 cycles, each result using the operands present at its acceptance edge. A pulse of start while busy=1 → ignored, result unchanged.
- Reset mid-run: drop reset at beat 2 → all outputs 0 immediately, no done. A fresh start after release completes normally.
